// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_sequencer: fetch-stage program counter with LUT jumps, return stack   |
// | and start/halt run control.                                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_sequencer #(
  parameter int D  = 12,
  parameter int LW = 5,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic          jump,
  input  logic          branch_en,
  input  logic          cond,
  input  logic          call,
  input  logic          ret,
  input  logic          halt,
  input  logic [LW-1:0] lut_idx,
  input  logic [D-1:0]  lut_target,
  output logic [LW-1:0] lut_addr,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic          stack_err
);

  localparam int SPW = $clog2(SD + 1);
  localparam int IW  = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [SPW-1:0] C_SP_FULL = SPW'(SD);
  localparam logic [SPW-1:0] C_SP_ONE  = SPW'(1);
  localparam logic [D-1:0]   C_PC_ONE  = D'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state, w_state_nx;
  logic [D-1:0]   r_pc, w_pc_nx, w_pc_inc;
  logic [SPW-1:0] r_sp, w_sp_nx, w_sp_m1;
  logic           r_err, w_err_nx;
  logic           r_running, r_done;
  logic           w_push;
  logic [IW-1:0]  w_top_idx, w_push_idx;
  logic [D-1:0]   r_stack [SD];

  assign lut_addr   = lut_idx;
  assign w_pc_inc   = r_pc + C_PC_ONE;
  assign w_sp_m1    = r_sp - C_SP_ONE;
  assign w_top_idx  = w_sp_m1[IW-1:0];
  assign w_push_idx = r_sp[IW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_sp      <= '0;
      r_err     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_sp      <= w_sp_nx;
      r_err     <= w_err_nx;
      r_running <= (w_state_nx == S_RUN);
      r_done    <= (w_state_nx == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SD; i++) r_stack[i] <= '0;
    end else if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  // Priority: halt > ret > call > jump/taken branch > increment.
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_sp_nx    = r_sp;
    w_err_nx   = r_err;
    w_push     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nx = S_RUN;
          w_pc_nx    = '0;
          w_sp_nx    = '0;
          w_err_nx   = 1'b0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (halt) begin
            w_state_nx = S_DONE;
          end else if (ret) begin
            if (r_sp != '0) begin
              w_pc_nx = r_stack[w_top_idx];
              w_sp_nx = w_sp_m1;
            end else begin
              w_err_nx = 1'b1;
              w_pc_nx  = w_pc_inc;
            end
          end else if (call) begin
            w_pc_nx = lut_target;
            if (r_sp != C_SP_FULL) begin
              w_push  = 1'b1;
              w_sp_nx = r_sp + C_SP_ONE;
            end else begin
              w_err_nx = 1'b1;
            end
          end else if (jump || (branch_en && cond)) begin
            w_pc_nx = lut_target;
          end else begin
            w_pc_nx = w_pc_inc;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign prog_ctr  = r_pc;
  assign running   = r_running;
  assign done      = r_done;
  assign stack_err = r_err;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the processor fetch stage. It holds the program counter and steps it each cycle. It resolves jumps and taken branches through the external branch-target lookup table by driving the table index and consuming the returned target. It also provides a small call/return stack and start/halt run control for the testbench handshake.

## Interface
- D, 12, program-counter and branch-target width
- LW, 5, lookup-table index width
- SD, 4, return-stack depth (entries)

- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  begin program execution (level sampled per cycle)
- Stall  in  1  hold PC and ignore all control inputs this cycle
- Jump  in  1  unconditional jump to lookup target
- BranchEn  in  1  conditional branch instruction present
- Cond  in  1  branch condition; taken when BranchEn & Cond
- Call  in  1  push return address, jump to lookup target
- Ret  in  1  pop return address into PC
- Halt  in  1  end of program
- LutIdx  in  LW  target index from instruction field
- LutTarget  in  D  target returned by lookup table
- LutAddr  out  LW  index to lookup table
- ProgCtr  out  D  current program counter (instruction memory address)
- Running  out  1  high in RUN state
- Done  out  1  high in DONE state
- StackErr  out  1  sticky return-stack overflow/underflow flag

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when Start=1.
  - RUN -> DONE on an accepted Halt.
  - DONE -> RUN when Start=1.
  - Start in RUN is ignored.
- LutAddr = LutIdx combinationally, in all states. The lookup table is combinational, so LutTarget is used in the same cycle.
- Control inputs are accepted only in RUN with Stall=0. In IDLE, in DONE, or when stalled, PC holds.
- Priority within an accepted cycle: Halt > Ret > Call > Jump > taken branch > increment.
  - Halt: PC holds and the state goes to DONE.
  - Ret, stack non-empty: PC <= top of stack, then pop.
  - Ret, stack empty: StackErr <= 1, PC <= PC+1.
  - Call, stack not full: push PC+1, PC <= LutTarget.
  - Call, stack full: push dropped, StackErr <= 1, PC <= LutTarget.
  - Jump, or BranchEn & Cond: PC <= LutTarget.
  - Otherwise: PC <= PC+1.
- Arithmetic: PC+1 is modulo 2^D, so 2^D-1 wraps to 0 with no flag. LutTarget is taken unmodified.
- Return stack: SD entries of D bits with a pointer 0..SD. Push and pop never occur in the same cycle.
- Start from DONE clears the PC, stack pointer and StackErr.

## Timing
- Reset (asynchronous assert, any time, including mid-program) forces:
  - state IDLE
  - ProgCtr=0, stack pointer=0
  - Running=0, Done=0, StackErr=0
- Start in IDLE: Running=1 from the next edge; ProgCtr stays 0, so instruction 0 executes in the first RUN cycle.
- Latency: every PC update is visible one cycle after the accepted control input. There are no bubbles or delay slots.
- Halt accepted at edge N: Done=1 and Running=0 after edge N. ProgCtr keeps the address of the halt instruction.
- Start in DONE at edge N: ProgCtr=0, Running=1 and Done=0 after edge N.
- Stall=1 in RUN: all control inputs, including Halt, are ignored. They must be re-presented once Stall drops.
- Outputs Running, Done, StackErr and ProgCtr are registered. LutAddr is the only combinational output.

## Test plan
- Reset, Start, free-run: ProgCtr reads 0,1,2,3 on successive cycles. Running=1, Done=0.
- Jump: LUT model maps idx0->13 and idx5->117. Jump with LutIdx=5 at PC=3 gives ProgCtr=117 next cycle. BranchEn=1 with Cond=0 at PC=117 gives 118. BranchEn=1, Cond=1, LutIdx=0 at PC=118 gives 13.
- Call and return: Call at PC=4 with LutIdx=0 gives PC=13. Stepping to 14 then Ret gives PC=5. StackErr stays 0.
- Stack errors: five nested Calls with SD=4; the fifth still jumps and StackErr=1. Ret on an empty stack at PC=20 gives PC=21 and StackErr=1.
- Simultaneous controls and stall:
  - Halt+Jump+Call in one cycle: Halt wins, Done=1, PC holds.
  - Stall=1 together with Jump: PC unchanged.
  - PC=4095 with increment wraps to 0.
- Restart and mid-run reset:
  - Start in DONE gives PC=0, Running=1, StackErr cleared.
  - Reset asserted mid-run at PC=50 forces ProgCtr=0 and IDLE immediately, without waiting for Clk.
